// File: rtl/wheel_mon_pkg.sv
// rtl/wheel_mon_pkg.sv - shared types and width helpers for the wheel speed monitor
package wheel_mon_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} avg_state_t;

    function automatic int acc_w(input int spd_w, input int log2_smpl);
        return spd_w + log2_smpl;
    endfunction

    // One extra bit so |lft - rght| at opposite extremes cannot wrap.
    function automatic int diff_w(input int spd_w);
        return spd_w + 1;
    endfunction

endpackage

// File: rtl/spd_accum.sv
// rtl/spd_accum.sv - signed per-wheel window accumulator with power-of-two averaging
module spd_accum
    import wheel_mon_pkg::*;
#(
    parameter int SPD_W     = 12,
    parameter int LOG2_SMPL = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    add_en,
    input  logic signed [SPD_W-1:0] din,
    output logic signed [SPD_W-1:0] avg_nxt
);

    localparam int ACC_W = acc_w(SPD_W, LOG2_SMPL);

    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = acc_q + {{LOG2_SMPL{din[SPD_W-1]}}, din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Dropping the low bits is an arithmetic shift (floor toward -inf); taken from the
    // next-state sum so the average is ready on the edge that accepts the last sample.
    assign avg_nxt = acc_d[ACC_W-1:LOG2_SMPL];

endmodule

// File: rtl/wheel_spd_avg.sv
// rtl/wheel_spd_avg.sv - windowed wheel speed averager with trend and mismatch monitor
module wheel_spd_avg
    import wheel_mon_pkg::*;
#(
    parameter int SPD_W     = 12,
    parameter int LOG2_SMPL = 10,
    parameter int TOL       = 10,
    parameter int MIS_RUN   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    smpl_vld,
    input  logic signed [SPD_W-1:0] lft_spd,
    input  logic signed [SPD_W-1:0] rght_spd,
    input  logic                    clr_mis,
    output logic                    busy,
    output logic                    avg_vld,
    output logic signed [SPD_W-1:0] lft_avg,
    output logic signed [SPD_W-1:0] rght_avg,
    output logic                    spd_up,
    output logic                    spd_dn,
    output logic                    mismatch
);

    localparam int DIFF_W = diff_w(SPD_W);
    localparam int CNT_W  = LOG2_SMPL + 1;
    localparam int RUN_W  = $clog2(MIS_RUN + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << LOG2_SMPL) - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MIS_RUN);
    localparam logic [DIFF_W-1:0] TOL_V    = DIFF_W'(TOL);

    avg_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic acc_clr, add_en, load;
    logic signed [SPD_W-1:0] lft_nxt, rght_nxt;

    logic                    avg_vld_q, avg_vld_d;
    logic signed [SPD_W-1:0] lft_avg_q, lft_avg_d;
    logic signed [SPD_W-1:0] rght_avg_q, rght_avg_d;
    logic                    spd_up_q, spd_up_d;
    logic                    spd_dn_q, spd_dn_d;
    logic                    prev_ok_q, prev_ok_d;

    logic [RUN_W-1:0]         run_q, run_d, run_inc;
    logic                     mis_q, mis_d, mis_set;
    logic signed [DIFF_W-1:0] dsgn;
    logic [DIFF_W-1:0]        diff;

    spd_accum #(.SPD_W(SPD_W), .LOG2_SMPL(LOG2_SMPL)) u_lft_accum (
        .clk(clk), .rst(rst), .clear(acc_clr), .add_en(add_en),
        .din(lft_spd), .avg_nxt(lft_nxt)
    );

    spd_accum #(.SPD_W(SPD_W), .LOG2_SMPL(LOG2_SMPL)) u_rght_accum (
        .clk(clk), .rst(rst), .clear(acc_clr), .add_en(add_en),
        .din(rght_spd), .avg_nxt(rght_nxt)
    );

    // A start inside a window restarts it and swallows any sample offered that cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_clr = 1'b0;
        add_en  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end else if (smpl_vld) begin
                    add_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // The held averages double as the previous window's values for the trend compare.
    always_comb begin
        avg_vld_d  = load;
        lft_avg_d  = lft_avg_q;
        rght_avg_d = rght_avg_q;
        spd_up_d   = spd_up_q;
        spd_dn_d   = spd_dn_q;
        prev_ok_d  = prev_ok_q;
        if (load) begin
            lft_avg_d  = lft_nxt;
            rght_avg_d = rght_nxt;
            spd_up_d   = prev_ok_q && (lft_nxt > lft_avg_q) && (rght_nxt > rght_avg_q);
            spd_dn_d   = prev_ok_q && (lft_nxt < lft_avg_q) && (rght_nxt < rght_avg_q);
            prev_ok_d  = 1'b1;
        end
    end

    always_comb begin
        dsgn    = {lft_spd[SPD_W-1], lft_spd} - {rght_spd[SPD_W-1], rght_spd};
        diff    = dsgn[DIFF_W-1] ? DIFF_W'(-dsgn) : DIFF_W'(dsgn);
        run_inc = '0;
        if (diff > TOL_V) begin
            run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        end
        mis_set = smpl_vld && (run_inc == RUN_MAX);
        run_d   = run_q;
        if (clr_mis) begin
            run_d = '0;
        end else if (smpl_vld) begin
            run_d = run_inc;
        end
        mis_d = mis_set ? 1'b1 : (clr_mis ? 1'b0 : mis_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            avg_vld_q  <= 1'b0;
            lft_avg_q  <= '0;
            rght_avg_q <= '0;
            spd_up_q   <= 1'b0;
            spd_dn_q   <= 1'b0;
            prev_ok_q  <= 1'b0;
            run_q      <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            avg_vld_q  <= avg_vld_d;
            lft_avg_q  <= lft_avg_d;
            rght_avg_q <= rght_avg_d;
            spd_up_q   <= spd_up_d;
            spd_dn_q   <= spd_dn_d;
            prev_ok_q  <= prev_ok_d;
            run_q      <= run_d;
            mis_q      <= mis_d;
        end
    end

    assign busy     = (state_q == ACCUM);
    assign avg_vld  = avg_vld_q;
    assign lft_avg  = lft_avg_q;
    assign rght_avg = rght_avg_q;
    assign spd_up   = spd_up_q;
    assign spd_dn   = spd_dn_q;
    assign mismatch = mis_q;

endmodule
